// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg
//   Shared definitions for the boot-time instruction loader: FSM state
//   encoding, word/byte geometry and a small state-decode helper.
package inst_mem_loader_pkg;

  // Instruction words are always assembled from four stream bytes.
  localparam int unsigned BYTES_PER_WORD = 32 / 8;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LEN0  = 3'd1;
  localparam state_t S_LEN1  = 3'd2;
  localparam state_t S_DATA  = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_CHK   = 3'd5;
  localparam state_t S_DONE  = 3'd6;
  localparam state_t S_ERR   = 3'd7;

  // States in which the loader consumes stream bytes.
  function automatic logic is_stream_state(input state_t s);
    return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CHK);
  endfunction

  // States in which a new load may be started.
  function automatic logic is_start_state(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/inst_mem_loader_packer.sv
// byte_to_word_packer
//   Assembles stream bytes LSB-first into an instruction word and keeps a
//   running XOR checksum of every byte it is given.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : zero byte index, partial word and checksum
//   byte_en       : in_byte is consumed this cycle
//   in_byte       : data byte
//   word_next     : word as it will be once in_byte is shifted in
//   word_ready    : this byte completes a word (combinational pulse)
//   checksum      : XOR of all bytes consumed since the last clear
module byte_to_word_packer
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            in_byte,
  output logic [WORD_WIDTH-1:0] word_next,
  output logic                  word_ready,
  output logic [7:0]            checksum
);

  logic [WORD_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      idx_q;

  // Bytes enter at the top and move down, so after a full word the first
  // byte has landed in bits [7:0].
  assign word_next  = {in_byte, shift_q[WORD_WIDTH-1:8]};
  assign word_ready = byte_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      idx_q    <= '0;
      checksum <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      idx_q    <= '0;
      checksum <= '0;
    end else if (byte_en) begin
      shift_q  <= word_next;
      checksum <= checksum ^ in_byte;
      idx_q    <= word_ready ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Boot-time DMA engine feeding the instruction memory write port from a
//   byte stream: 16-bit LE word count, LE instruction words, XOR checksum.
//   cpu_clk, cpu_rst       : clock, asynchronous active-high reset
//   load_start             : begin a load (IDLE/DONE/ERR only)
//   s_byte/s_valid/s_ready : byte stream handshake
//   dma_inst_mem_waddr     : word address of the write
//   dma_inst_mem_wdata     : assembled instruction word
//   inst_mem_write         : one-cycle write strobe per word
//   cpu_hold               : stall the CPU while loading / after a failure
//   load_done, load_err    : sticky outcome of the last load
//   words_written          : words written by the current/last load
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned NUM_WORDS       = 128,
  parameter bit          BOOT_HOLD       = 1'b0
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       load_start,
  input  logic [7:0]                 s_byte,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [INST_WIDTH-1:0]      dma_inst_mem_wdata,
  output logic                       inst_mem_write,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic                       load_err,
  output logic [15:0]                words_written
);

  state_t                state_q, state_d;
  logic [15:0]           len_q;
  logic [15:0]           len_hdr;
  logic                  accept;
  logic                  start_go;
  logic                  len_too_big;
  logic                  byte_en;
  logic                  word_ready;
  logic [INST_WIDTH-1:0] word_next;
  logic [7:0]            checksum;
  logic                  chk_match;

  // s_ready is a registered decode of the state, so it always agrees with
  // state_q and the handshake needs no extra qualification.
  assign accept      = s_valid && s_ready;
  assign start_go    = load_start && is_start_state(state_q);
  assign len_hdr     = {s_byte, len_q[7:0]};
  assign len_too_big = {1'b0, len_hdr} > 17'(NUM_WORDS);
  assign byte_en     = accept && (state_q == S_DATA);
  assign chk_match   = (s_byte == checksum);

  byte_to_word_packer #(
    .WORD_WIDTH (INST_WIDTH)
  ) u_packer (
    .clk        (cpu_clk),
    .rst        (cpu_rst),
    .clear      (start_go),
    .byte_en    (byte_en),
    .in_byte    (s_byte),
    .word_next  (word_next),
    .word_ready (word_ready),
    .checksum   (checksum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (load_start) state_d = S_LEN0;
      S_LEN0:
        if (accept) state_d = S_LEN1;
      S_LEN1:
        if (accept) begin
          if (len_too_big)           state_d = S_ERR;
          else if (len_hdr == 16'd0) state_d = S_CHK;
          else                       state_d = S_DATA;
        end
      S_DATA:
        if (word_ready) state_d = S_WRITE;
      S_WRITE:
        state_d = ((words_written + 16'd1) == len_q) ? S_CHK : S_DATA;
      S_CHK:
        if (accept) state_d = chk_match ? S_DONE : S_ERR;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Outputs are loaded from the next-state decode so that each one is a
  // plain flop yet lines up with the state it belongs to.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q            <= S_IDLE;
      s_ready            <= 1'b0;
      inst_mem_write     <= 1'b0;
      dma_inst_mem_waddr <= '0;
      dma_inst_mem_wdata <= '0;
      cpu_hold           <= BOOT_HOLD;
      load_done          <= 1'b0;
      load_err           <= 1'b0;
      words_written      <= '0;
      len_q              <= '0;
    end else begin
      state_q        <= state_d;
      s_ready        <= is_stream_state(state_d);
      inst_mem_write <= (state_d == S_WRITE);

      if (start_go) begin
        cpu_hold      <= 1'b1;
        load_done     <= 1'b0;
        load_err      <= 1'b0;
        words_written <= '0;
      end

      if (accept && (state_q == S_LEN0)) len_q[7:0] <= s_byte;

      if (accept && (state_q == S_LEN1)) begin
        len_q[15:8] <= s_byte;
        if (len_too_big) load_err <= 1'b1;
      end

      if (word_ready) begin
        dma_inst_mem_waddr <= INST_ADDR_WIDTH'(words_written);
        dma_inst_mem_wdata <= word_next;
      end

      if (state_q == S_WRITE) words_written <= words_written + 16'd1;

      if (accept && (state_q == S_CHK)) begin
        if (chk_match) begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
        end else begin
          load_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  logic        cpu_clk    = 1'b0;
  logic        cpu_rst    = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  s_byte     = '0;
  logic        s_valid    = 1'b0;
  logic        s_ready;
  logic [31:0] dma_inst_mem_waddr;
  logic [31:0] dma_inst_mem_wdata;
  logic        inst_mem_write;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_written;

  inst_mem_loader #(
    .INST_WIDTH      (32),
    .INST_ADDR_WIDTH (32),
    .NUM_WORDS       (128),
    .BOOT_HOLD       (1'b0)
  ) dut (
    .cpu_clk            (cpu_clk),
    .cpu_rst            (cpu_rst),
    .load_start         (load_start),
    .s_byte             (s_byte),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .dma_inst_mem_waddr (dma_inst_mem_waddr),
    .dma_inst_mem_wdata (dma_inst_mem_wdata),
    .inst_mem_write     (inst_mem_write),
    .cpu_hold           (cpu_hold),
    .load_done          (load_done),
    .load_err           (load_err),
    .words_written      (words_written)
  );

  always #5 cpu_clk = ~cpu_clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int unsigned wr_cyc  [$];
  int unsigned acc_cyc [16];

  always @(negedge cpu_clk) begin
    if (inst_mem_write === 1'b1) begin
      wr_addr.push_back(dma_inst_mem_waddr);
      wr_data.push_back(dma_inst_mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct packed {
    logic [7:0]        nbytes;
    logic [0:15][7:0]  bytes;
    logic [2:0]        nwr;
    logic [0:3][31:0]  wdata;
    logic              done;
    logic              err;
    logic              hold;
    logic [15:0]       ww;
  } load_vec_t;

  load_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input int unsigned slot);
    int unsigned n = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge cpu_clk);
      #1;
    end
    s_byte  = b;
    s_valid = 1'b1;
    @(negedge cpu_clk);
    while (!s_ready && n < 40) begin
      @(negedge cpu_clk);
      n++;
    end
    if (!s_ready) begin
      check("s_ready_wait_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge cpu_clk);
      #1;
      s_valid = 1'b0;
      if (slot < 16) acc_cyc[slot] = cyc;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge cpu_clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic wait_outcome();
    int unsigned n = 0;
    while (!(load_done || load_err) && n < 30) begin
      @(negedge cpu_clk);
      n++;
    end
    if (!(load_done || load_err)) check("outcome_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_write"},   32'(inst_mem_write), 32'd0);
    check({tag, "_hold"},    32'(cpu_hold), 32'd0);
    check({tag, "_done"},    32'(load_done), 32'd0);
    check({tag, "_err"},     32'(load_err), 32'd0);
    check({tag, "_ww"},      32'(words_written), 32'd0);
    check({tag, "_waddr"},   dma_inst_mem_waddr, 32'd0);
    check({tag, "_wdata"},   dma_inst_mem_wdata, 32'd0);
  endtask

  task automatic run_vec(input load_vec_t v, input int idx, input bit gaps);
    string tag;
    tag = $sformatf("v%0d%s", idx, gaps ? "g" : "");
    clear_log();
    pulse_start();
    check({tag, "_start_done"}, 32'(load_done), 32'd0);
    check({tag, "_start_err"},  32'(load_err), 32'd0);
    check({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_start_rdy"},  32'(s_ready), 32'd1);
    check({tag, "_start_ww"},   32'(words_written), 32'd0);
    for (int i = 0; i < int'(v.nbytes); i++) begin
      send_byte(v.bytes[i], gaps ? $urandom_range(0, 3) : 0, i);
      if (gaps && i == 3) begin
        pulse_start();
        check({tag, "_midstart_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_midstart_rdy"},  32'(s_ready), 32'd1);
      end
    end
    wait_outcome();
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(v.nwr));
    for (int j = 0; j < int'(v.nwr); j++) begin
      if (j < wr_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, j), wr_addr[j], 32'(j));
        check($sformatf("%s_data%0d", tag, j), wr_data[j], v.wdata[j]);
        check($sformatf("%s_lat%0d", tag, j), wr_cyc[j], acc_cyc[2 + 4*j + 3]);
      end
    end
    if (!gaps && v.nwr >= 2 && wr_cyc.size() >= 2)
      check({tag, "_spacing"}, wr_cyc[1] - wr_cyc[0], 32'd5);
    check({tag, "_done"},  32'(load_done), 32'(v.done));
    check({tag, "_err"},   32'(load_err), 32'(v.err));
    check({tag, "_hold"},  32'(cpu_hold), 32'(v.hold));
    check({tag, "_ww"},    32'(words_written), 32'(v.ww));
    check({tag, "_rdy"},   32'(s_ready), 32'd0);
    check({tag, "_write"}, 32'(inst_mem_write), 32'd0);
  endtask

  initial begin
    // Good 2-word load: data bytes XOR to 0xC0.
    vecs[0] = '{nbytes: 8'd11,
                bytes: {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00,
                        8'h10, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nwr: 3'd2, wdata: {32'h00500013, 32'h00100093, 32'h0, 32'h0},
                done: 1'b1, err: 1'b0, hold: 1'b0, ww: 16'd2};
    // Same words, bad checksum.
    vecs[1] = vecs[0];
    vecs[1].bytes[10] = 8'h00;
    vecs[1].done = 1'b0; vecs[1].err = 1'b1; vecs[1].hold = 1'b1;
    // Length 129 exceeds capacity.
    vecs[2] = '{nbytes: 8'd2, bytes: {8'h81, 8'h00, {14{8'h00}}},
                nwr: 3'd0, wdata: '0, done: 1'b0, err: 1'b1, hold: 1'b1, ww: 16'd0};
    // Zero-length load: checksum of nothing is 0.
    vecs[3] = '{nbytes: 8'd3, bytes: {8'h00, 8'h00, 8'h00, {13{8'h00}}},
                nwr: 3'd0, wdata: '0, done: 1'b1, err: 1'b0, hold: 1'b0, ww: 16'd0};
    // One word 0xDEADBEEF, checksum EF^BE^AD^DE = 0x22.
    vecs[4] = '{nbytes: 8'd7,
                bytes: {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22, {9{8'h00}}},
                nwr: 3'd1, wdata: {32'hDEADBEEF, 32'h0, 32'h0, 32'h0},
                done: 1'b1, err: 1'b0, hold: 1'b0, ww: 16'd1};
    // Three words 11223344, 00000000, FFFFFFFF; checksum 0x44.
    vecs[5] = '{nbytes: 8'd15,
                bytes: {8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h44, 8'h00},
                nwr: 3'd3, wdata: {32'h11223344, 32'h00000000, 32'hFFFFFFFF, 32'h0},
                done: 1'b1, err: 1'b0, hold: 1'b0, ww: 16'd3};

    // Reset state, during and after reset with no stimulus.
    #12;
    check_reset_values("rst_held");
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    check_reset_values("rst_idle");

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k, 1'b0);

    // Stalled stream and an ignored mid-DATA load_start must not change the result.
    run_vec(vecs[0], 0, 1'b1);
    run_vec(vecs[5], 5, 1'b1);

    // Length exactly at capacity is accepted.
    clear_log();
    pulse_start();
    send_byte(8'h80, 0, 16);
    send_byte(8'h00, 0, 16);
    @(negedge cpu_clk);
    check("len128_err",  32'(load_err), 32'd0);
    check("len128_rdy",  32'(s_ready), 32'd1);
    check("len128_hold", 32'(cpu_hold), 32'd1);
    #2;
    cpu_rst = 1'b1;
    #1;
    check_reset_values("len128_rst");
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;

    // Reset after two data bytes of a 3-word load.
    pulse_start();
    send_byte(8'h03, 0, 16);
    send_byte(8'h00, 0, 16);
    send_byte(8'hAA, 0, 16);
    send_byte(8'hBB, 0, 16);
    check("midload_rdy_before", 32'(s_ready), 32'd1);
    #2;
    cpu_rst = 1'b1;
    #1;
    check_reset_values("midload_rst");
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;

    // Reset while the write strobe is high drops it immediately.
    pulse_start();
    send_byte(8'h01, 0, 16);
    send_byte(8'h00, 0, 16);
    send_byte(8'h01, 0, 16);
    send_byte(8'h02, 0, 16);
    send_byte(8'h03, 0, 16);
    send_byte(8'h04, 0, 16);
    check("wrrst_strobe_before", 32'(inst_mem_write), 32'd1);
    check("wrrst_wdata_before",  dma_inst_mem_wdata, 32'h04030201);
    #2;
    cpu_rst = 1'b1;
    #1;
    check_reset_values("wrrst_rst");
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;
    @(posedge cpu_clk);
    #1;

    // Full load after the aborted ones.
    run_vec(vecs[4], 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
